systolic_mac_pe: RTL and testbench
==================================

# systolic_mac_pe

Parametrised multiply-accumulate processing element for the systolic matrix multiplier array. Each cycle it forwards its A and B operands, registered, to its right and lower neighbours. It accumulates their product into a local dot-product register, with framing (`in_last`), signed/unsigned mode, and saturating or wrapping overflow. Completed results are presented on a valid/ready result port, so the array controller can drain results while the next dot product is already streaming.

## Interface
Parameters:
- `DATA_W`, 8, operand width
- `ACC_W`, 20, accumulator/result width; must be ≥ 2*DATA_W
- `SIGNED`, 0, 1 = two's-complement operands and accumulator; 0 = unsigned
- `SATURATE`, 1, 1 = clamp on overflow; 0 = modulo-2^ACC_W wrap

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  `ain`/`bin` carry a term this cycle
- `in_last`  in  1  qualifies the final term of a dot product; ignored unless `in_valid`
- `ain`  in  DATA_W  A operand (from left neighbour)
- `bin`  in  DATA_W  B operand (from upper neighbour)
- `aout`  out  DATA_W  registered `ain` to right neighbour
- `bout`  out  DATA_W  registered `bin` to lower neighbour
- `fwd_valid`  out  1  registered `in_valid`
- `fwd_last`  out  1  registered `in_valid & in_last`
- `res`  out  ACC_W  completed dot product
- `res_valid`  out  1  `res` holds an unconsumed result
- `res_ready`  in  1  consumer accepts `res` when `res_valid & res_ready`
- `res_ovf`  out  1  an overflow occurred in the dot product now on `res`
- `res_overrun`  out  1  sticky: an unconsumed result was overwritten; cleared only by `RST`

## Operation
- Forwarding path never stalls.
  - `aout`, `bout`, `fwd_valid` and `fwd_last` register their inputs every cycle, independent of result state.
  - Data registers load even when `in_valid`=0.
- Product: DATA_W×DATA_W → 2*DATA_W bits, signed or unsigned per `SIGNED`.
  - It is sign- or zero-extended to ACC_W+1 bits before the add.
- Accumulator FSM has two states.
  - IDLE: no term yet in the current dot product; `acc` is don't-care.
  - ACCUM: at least one term has been accumulated.
- FSM transitions on `in_valid`:
  - IDLE & !`in_last` → ACCUM, with `acc` = ext(product) and `ovf` = 0.
  - ACCUM & !`in_last` → ACCUM, with `acc` = sat_or_wrap(`acc` + product). `ovf` is set if that add overflowed.
  - any state & `in_last` → IDLE. The final sum (term added to 0 if in IDLE) is loaded into `res`, and `ovf` for that final add is loaded into `res_ovf`. `res_valid` is set.
  - `in_valid`=0: state and `acc` hold.
- Overflow:
  - Signed: sum outside [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Unsigned: sum > 2^ACC_W−1.
  - SATURATE=1: the result clamps to the violated bound.
  - SATURATE=0: the low ACC_W bits are kept.
  - The overflow flag is raised in both modes.
  - Once saturated, `acc` continues to accumulate from the clamped value.
- Result port:
  - `res_valid` clears on `res_valid & res_ready` unless a new result loads in the same cycle.
  - New result loads while `res_valid` & !`res_ready`: the new value overwrites `res` and `res_overrun` is set to 1.
  - New result loads in the same cycle as the handshake: the new value loads, `res_valid` stays 1, and there is no overrun.

## Timing
- Reset values:
  - All outputs are 0: `aout`, `bout`, `fwd_valid`, `fwd_last`, `res`, `res_valid`, `res_ovf` and `res_overrun`.
  - FSM goes to IDLE.
  - `RST` has priority over all other inputs.
- `RST` during ACCUM discards the partial sum. The next valid term starts a new dot product.
- Latency:
  - Forward path: 1 cycle.
  - Result: `res_valid`=1 in the cycle after the `in_last` term is sampled.
  - A single-term dot product (`in_last` on the first term) is legal. It produces `res` = product after 1 cycle.
- Throughput: one term per cycle, with no bubble required between dot products.
  - Term after `in_last` starts a fresh dot product from IDLE.
- `res_ready` is sampled only while `res_valid`=1.

## Test plan
- Basic accumulation:
  - Stimulus: unsigned; terms (3,2), (4,2) and (5,2) on consecutive cycles, with `in_last` on the third and `res_ready`=1.
  - Required response: `res`=24, `res_valid` high for exactly one cycle, the cycle after the third term, `res_ovf`=0.
  - Also check: `aout`/`bout` echo 3,4,5 / 2,2,2 one cycle late.
- Signed saturation:
  - Stimulus: `SIGNED`=1; 33 terms of (−128,−128), each product 16384.
  - Required response: `res`=524287, `res_ovf`=1.
  - Repeat with SATURATE=0: `res` = 540672 mod 2^20 reinterpreted as signed = −507904, `res_ovf`=1.
- Unsigned saturation:
  - Stimulus: 17 terms of (255,255).
  - Required response: `res`=1048575, `res_ovf`=1.
  - Next dot product (1,1) with last: `res`=1, `res_ovf`=0.
- Back-to-back framing with gaps:
  - Stimulus: dot product (2,3)+(1,1) last, immediately followed by (7,7) last, with `in_valid` gaps inserted mid-product.
  - Required response: `res`=7 then 49, the gaps not affecting sums, `fwd_valid` mirroring `in_valid` delayed 1 cycle.
- Backpressure and overrun:
  - Stimulus: `res_ready`=0; two dot products complete, results 10 then 20.
  - Required response: `res`=20, `res_valid`=1, `res_overrun`=1.
  - Then raise `res_ready` in the same cycle a third result 30 loads: `res`=30, `res_valid` stays 1.
- Reset mid-operation:
  - Stimulus: assert `RST` after two of four terms.
  - Required response: all outputs 0 in the next cycle.
  - Then a fresh (6,6) last term: `res`=36, and the discarded partial sum is not included.

Source files
------------

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe
//   One processing element of the systolic matrix multiplier. Operands are
//   forwarded (registered) to the right/lower neighbours every cycle, and
//   their product is accumulated into a local dot-product register. The
//   dot product is framed by in_last. Completed sums appear on a valid/ready
//   result port, so the next dot product can stream while the previous
//   result is still being drained.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   in_valid, in_last   term qualifier / final-term marker (last needs valid)
//   ain, bin            operands from left / upper neighbour
//   aout, bout          registered operands to right / lower neighbour
//   fwd_valid, fwd_last registered in_valid and in_valid & in_last
//   res, res_valid      completed dot product and its valid flag
//   res_ready           consumer accepts res when res_valid & res_ready
//   res_ovf             an overflow occurred somewhere in the dot product on res
//   res_overrun         sticky: an unconsumed result was overwritten
module systolic_mac_pe #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [DATA_W-1:0] ain,
  input  logic [DATA_W-1:0] bin,
  output logic [DATA_W-1:0] aout,
  output logic [DATA_W-1:0] bout,
  output logic              fwd_valid,
  output logic              fwd_last,
  output logic [ACC_W-1:0]  res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_ovf,
  output logic              res_overrun
);

  // Product is 2*DATA_W bits; it is widened to ACC_W+1 so that the carry /
  // sign-overflow bit of the accumulate is visible in sum[ACC_W].
  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W + 1 - PROD_W;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state, state_nxt;
  logic               load_acc, load_res;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [ACC_W:0]     prod_ext, base_ext, sum;
  logic [ACC_W-1:0]   clamp, sum_fix;
  logic               add_ovf, prior_ovf;

  // ---------------------------------------------------------------------------
  // Accumulator FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    load_acc  = 1'b0;
    load_res  = 1'b0;
    if (in_valid) begin
      if (in_last) begin
        state_nxt = IDLE;
        load_res  = 1'b1;
      end else begin
        state_nxt = ACCUM;
        load_acc  = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: in IDLE the running sum is treated as zero, so the first term
  // of a dot product (including a single-term one) is just ext(product).
  // ---------------------------------------------------------------------------
  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [PROD_W-1:0] a_x, b_x, prod;
      assign a_x      = {{DATA_W{ain[DATA_W-1]}}, ain};
      assign b_x      = {{DATA_W{bin[DATA_W-1]}}, bin};
      assign prod     = a_x * b_x;
      assign prod_ext = {{EXT_W{prod[PROD_W-1]}}, prod};
      assign base_ext = (state == ACCUM) ? {acc[ACC_W-1], acc} : '0;
      // Signed overflow: the extra sign bit disagrees with the result MSB.
      assign add_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
      assign clamp    = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin : g_unsigned
      logic [PROD_W-1:0] a_x, b_x, prod;
      assign a_x      = {{DATA_W{1'b0}}, ain};
      assign b_x      = {{DATA_W{1'b0}}, bin};
      assign prod     = a_x * b_x;
      assign prod_ext = {{EXT_W{1'b0}}, prod};
      assign base_ext = (state == ACCUM) ? {1'b0, acc} : '0;
      assign add_ovf  = sum[ACC_W];
      assign clamp    = '1;
    end
  endgenerate

  assign sum       = base_ext + prod_ext;
  assign sum_fix   = (add_ovf && (SATURATE != 0)) ? clamp : sum[ACC_W-1:0];
  // Overflow flag is sticky across the whole dot product: a wrapped sum can
  // come back into range on a later term and still be wrong.
  assign prior_ovf = (state == ACCUM) && ovf;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      aout        <= '0;
      bout        <= '0;
      fwd_valid   <= 1'b0;
      fwd_last    <= 1'b0;
      acc         <= '0;
      ovf         <= 1'b0;
      res         <= '0;
      res_valid   <= 1'b0;
      res_ovf     <= 1'b0;
      res_overrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      aout      <= ain;
      bout      <= bin;
      fwd_valid <= in_valid;
      fwd_last  <= in_valid & in_last;

      if (load_acc) begin
        acc <= sum_fix;
        ovf <= add_ovf | prior_ovf;
      end

      if (load_res) begin
        res       <= sum_fix;
        res_ovf   <= add_ovf | prior_ovf;
        res_valid <= 1'b1;
        // Loading over a result nobody took this cycle loses that result.
        if (res_valid && !res_ready)
          res_overrun <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Testbench for systolic_mac_pe: four instances (unsigned/signed x
// saturate/wrap) share one stimulus stream; every cycle all outputs are
// compared against an arithmetic reference model, plus directed checks of
// the key values of each scenario.
module tb_systolic_mac_pe;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b0;
  logic [7:0] ain = '0, bin = '0;

  logic [7:0]  aout [4];
  logic [7:0]  bout [4];
  logic        fwd_valid [4], fwd_last [4];
  logic [19:0] res [4];
  logic        res_valid [4], res_ovf [4], res_overrun [4];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // k: 0 unsigned/sat, 1 unsigned/wrap, 2 signed/sat, 3 signed/wrap
  for (genvar k = 0; k < 4; k++) begin : g_dut
    systolic_mac_pe #(
      .DATA_W(8), .ACC_W(20), .SIGNED(k / 2), .SATURATE((k % 2 == 0) ? 1 : 0)
    ) u_dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_last(in_last),
      .ain(ain), .bin(bin), .aout(aout[k]), .bout(bout[k]),
      .fwd_valid(fwd_valid[k]), .fwd_last(fwd_last[k]),
      .res(res[k]), .res_valid(res_valid[k]), .res_ready(res_ready),
      .res_ovf(res_ovf[k]), .res_overrun(res_overrun[k])
    );
  end

  // ---------------- reference model ----------------
  logic [7:0] m_aout = '0, m_bout = '0;
  bit         m_fv = 0, m_fl = 0;
  bit         m_act [4], m_ovf [4], m_rv [4], m_rovf [4], m_or [4];
  longint     m_acc [4], m_res [4];

  function automatic longint sx(input logic [7:0] x);
    return x[7] ? longint'(x) - 256 : longint'(x);
  endfunction

  task automatic model(input bit v, l, input logic [7:0] a, b,
                       input bit rdy, rst);
    longint p, s, r, lo, hi;
    bit o, sg;
    if (rst) begin
      m_aout = '0; m_bout = '0; m_fv = 0; m_fl = 0;
      for (int c = 0; c < 4; c++) begin
        m_act[c] = 0; m_ovf[c] = 0; m_acc[c] = 0; m_res[c] = 0;
        m_rv[c] = 0; m_rovf[c] = 0; m_or[c] = 0;
      end
      return;
    end
    m_aout = a; m_bout = b; m_fv = v; m_fl = v & l;
    for (int c = 0; c < 4; c++) begin
      sg = (c >= 2);
      lo = sg ? -524288 : 0;
      hi = sg ? 524287 : 1048575;
      p  = sg ? sx(a) * sx(b) : longint'(a) * longint'(b);
      s  = (m_act[c] ? m_acc[c] : 0) + p;
      o  = (s > hi) || (s < lo);
      if (!o)                r = s;
      else if (c % 2 == 0)   r = (s > hi) ? hi : lo;
      else begin
        r = s & 64'hF_FFFF;
        if (sg && r >= 524288) r = r - 1048576;
      end
      if (v && l) begin
        if (m_rv[c] && !rdy) m_or[c] = 1;
        m_res[c]  = r;
        m_rovf[c] = o | (m_act[c] & m_ovf[c]);
        m_rv[c]   = 1;
        m_act[c]  = 0;
      end else begin
        if (v) begin
          m_ovf[c] = o | (m_act[c] & m_ovf[c]);
          m_acc[c] = r;
          m_act[c] = 1;
        end
        if (m_rv[c] && rdy) m_rv[c] = 0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("aout%0d", c), 32'(aout[c]), 32'(m_aout));
      chk($sformatf("bout%0d", c), 32'(bout[c]), 32'(m_bout));
      chk($sformatf("fwd_valid%0d", c), 32'(fwd_valid[c]), 32'(m_fv));
      chk($sformatf("fwd_last%0d", c), 32'(fwd_last[c]), 32'(m_fl));
      chk($sformatf("res%0d", c), 32'(res[c]), 32'(m_res[c][19:0]));
      chk($sformatf("res_valid%0d", c), 32'(res_valid[c]), 32'(m_rv[c]));
      chk($sformatf("res_ovf%0d", c), 32'(res_ovf[c]), 32'(m_rovf[c]));
      chk($sformatf("res_overrun%0d", c), 32'(res_overrun[c]), 32'(m_or[c]));
    end
  endtask

  task automatic step(input bit v, l, input logic [7:0] a, b,
                      input bit rdy = 1, input bit rst = 0);
    @(negedge CLK);
    in_valid = v; in_last = l; ain = a; bin = b; res_ready = rdy; RST = rst;
    @(posedge CLK);
    model(v, l, a, b, rdy, rst);
    #1 check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    step(0, 0, 8'h00, 8'h00, 0, 1);
    step(0, 0, 8'h5A, 8'hA5, 0, 1);
    chk("reset_res_valid", 32'(res_valid[0]), 0);

    // Basic accumulation: 3*2 + 4*2 + 5*2 = 24
    step(1, 0, 8'd3, 8'd2);
    chk("basic_aout", 32'(aout[0]), 3);
    step(1, 0, 8'd4, 8'd2);
    step(1, 1, 8'd5, 8'd2);
    chk("basic_res", 32'(res[0]), 24);
    chk("basic_valid", 32'(res_valid[0]), 1);
    chk("basic_ovf", 32'(res_ovf[0]), 0);
    chk("basic_bout", 32'(bout[0]), 2);
    step(0, 0, 8'd0, 8'd0);
    chk("basic_valid_drop", 32'(res_valid[0]), 0);

    // Signed saturation / wrap: 33 x (-128 * -128)
    for (int i = 0; i < 33; i++) step(1, i == 32, 8'h80, 8'h80);
    chk("ssat_res", 32'(res[2]), 32'h7FFFF);
    chk("ssat_ovf", 32'(res_ovf[2]), 1);
    chk("swrap_res", 32'(res[3]), 32'h84000);
    chk("swrap_ovf", 32'(res_ovf[3]), 1);

    // Unsigned saturation: 17 x (255 * 255), then 1*1
    for (int i = 0; i < 17; i++) step(1, i == 16, 8'hFF, 8'hFF);
    chk("usat_res", 32'(res[0]), 32'hFFFFF);
    chk("usat_ovf", 32'(res_ovf[0]), 1);
    step(1, 1, 8'd1, 8'd1);
    chk("usat_next_res", 32'(res[0]), 1);
    chk("usat_next_ovf", 32'(res_ovf[0]), 0);

    // Back-to-back framing with gaps
    step(1, 0, 8'd2, 8'd3);
    step(0, 0, 8'd9, 8'd9);
    step(0, 1, 8'd9, 8'd9);
    step(1, 1, 8'd1, 8'd1);
    chk("gap_res7", 32'(res[0]), 7);
    step(1, 1, 8'd7, 8'd7);
    chk("gap_res49", 32'(res[0]), 49);
    chk("gap_valid", 32'(res_valid[0]), 1);
    step(0, 0, 8'd0, 8'd0, 1);

    // Backpressure and overrun
    step(1, 1, 8'd5, 8'd2, 0);
    step(0, 0, 8'd0, 8'd0, 0);
    step(1, 1, 8'd4, 8'd5, 0);
    chk("bp_res20", 32'(res[0]), 20);
    chk("bp_valid", 32'(res_valid[0]), 1);
    chk("bp_overrun", 32'(res_overrun[0]), 1);
    step(1, 1, 8'd6, 8'd5, 1);
    chk("bp_res30", 32'(res[0]), 30);
    chk("bp_valid30", 32'(res_valid[0]), 1);
    step(0, 0, 8'd0, 8'd0, 1);
    chk("bp_drain", 32'(res_valid[0]), 0);

    // Reset mid-operation
    step(1, 0, 8'd1, 8'd1);
    step(1, 0, 8'd2, 8'd2);
    step(1, 0, 8'd3, 8'd3, 1, 1);
    chk("rst_overrun", 32'(res_overrun[0]), 0);
    chk("rst_aout", 32'(aout[0]), 0);
    step(1, 1, 8'd6, 8'd6);
    chk("rst_res36", 32'(res[0]), 36);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, a, b,
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
